// File: rtl/wb_mem_arbiter.sv
// Two-master Wishbone arbiter onto one slave: round-robin grant, one-cycle GAP between owners.
// Latency: grant 1 cycle after request; losing master is held off (no ack) until granted; stalled slave aborts on TIMEOUT.
module wb_mem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 14,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_cyc_i,
    input  logic                  m0_stb_i,
    input  logic                  m0_we_i,
    input  logic [ADDR_WIDTH-1:0] m0_adr_i,
    input  logic [DATA_WIDTH-1:0] m0_dat_i,
    output logic [DATA_WIDTH-1:0] m0_dat_o,
    output logic                  m0_ack_o,
    output logic                  m0_err_o,
    input  logic                  m1_cyc_i,
    input  logic                  m1_stb_i,
    input  logic                  m1_we_i,
    input  logic [ADDR_WIDTH-1:0] m1_adr_i,
    input  logic [DATA_WIDTH-1:0] m1_dat_i,
    output logic [DATA_WIDTH-1:0] m1_dat_o,
    output logic                  m1_ack_o,
    output logic                  m1_err_o,
    output logic                  s_cyc_o,
    output logic                  s_stb_o,
    output logic                  s_we_o,
    output logic [ADDR_WIDTH-1:0] s_adr_o,
    output logic [DATA_WIDTH-1:0] s_dat_o,
    input  logic [DATA_WIDTH-1:0] s_dat_i,
    input  logic                  s_ack_i,
    output logic [1:0]            grant_o
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BUSY0 = 2'd1;
    localparam logic [1:0] BUSY1 = 2'd2;
    localparam logic [1:0] GAP   = 2'd3;

    localparam logic [7:0] TO_LIM = TIMEOUT[7:0];

    logic [1:0]            state;
    logic [1:0]            state_nxt;
    logic [7:0]            cnt;
    logic                  last_grant;
    logic                  req0;
    logic                  req1;
    logic                  busy0;
    logic                  busy1;
    logic                  busy;
    logic                  own_cyc;
    logic                  own_stb;
    logic                  own_we;
    logic [ADDR_WIDTH-1:0] own_adr;
    logic [DATA_WIDTH-1:0] own_dat;
    logic                  timed_out;
    logic                  ack_ok;
    logic                  err_ok;
    logic                  arb_state;
    logic                  entering;

    assign req0  = m0_cyc_i && m0_stb_i;
    assign req1  = m1_cyc_i && m1_stb_i;

    // Outputs are gated by rst so everything reads 0 while reset is held, even before the first edge.
    assign busy0 = (state == BUSY0) && !rst;
    assign busy1 = (state == BUSY1) && !rst;
    assign busy  = busy0 || busy1;

    always_comb begin
        own_cyc = m0_cyc_i;
        own_stb = m0_stb_i;
        own_we  = m0_we_i;
        own_adr = m0_adr_i;
        own_dat = m0_dat_i;
        if (busy1) begin
            own_cyc = m1_cyc_i;
            own_stb = m1_stb_i;
            own_we  = m1_we_i;
            own_adr = m1_adr_i;
            own_dat = m1_dat_i;
        end
    end

    // A dropped cycle beats a timeout, and a timeout beats a late ack.
    assign timed_out = busy && (cnt == TO_LIM);
    assign ack_ok    = busy && own_cyc && s_ack_i && !timed_out;
    assign err_ok    = busy && own_cyc && timed_out;

    assign s_cyc_o  = busy && own_cyc;
    assign s_stb_o  = busy && own_stb;
    assign s_we_o   = busy && own_we;
    assign s_adr_o  = busy ? own_adr : '0;
    assign s_dat_o  = busy ? own_dat : '0;

    assign m0_ack_o = busy0 && ack_ok && m0_stb_i;
    assign m1_ack_o = busy1 && ack_ok && m1_stb_i;
    assign m0_err_o = busy0 && err_ok;
    assign m1_err_o = busy1 && err_ok;
    assign m0_dat_o = busy0 ? s_dat_i : '0;
    assign m1_dat_o = busy1 ? s_dat_i : '0;
    assign grant_o  = {busy1, busy0};

    assign arb_state = (state == IDLE) || (state == GAP);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, GAP: begin
                if (req0 && req1)
                    state_nxt = last_grant ? BUSY0 : BUSY1;
                else if (req0)
                    state_nxt = BUSY0;
                else if (req1)
                    state_nxt = BUSY1;
                else
                    state_nxt = IDLE;
            end
            BUSY0, BUSY1: begin
                if (!own_cyc || timed_out || s_ack_i)
                    state_nxt = GAP;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign entering = arb_state && ((state_nxt == BUSY0) || (state_nxt == BUSY1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 8'd0;
            last_grant <= 1'b1;
        end else begin
            state <= state_nxt;
            if (entering) begin
                cnt        <= 8'd0;
                last_grant <= (state_nxt == BUSY1);
            end else if (busy && !s_ack_i) begin
                cnt <= cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Bench for wb_mem_arbiter: registered-ack slave model, queue-driven masters, scoreboard of expected acks.
module tb_wb_mem_arbiter;

    localparam int DW = 32;
    localparam int AW = 14;
    localparam int TO = 6;

    typedef struct {
        logic          we;
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
    } mreq_t;

    typedef struct {
        int            m;
        logic          rd;
        logic [DW-1:0] d;
        int            cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          m0_cyc = 1'b0, m0_stb = 1'b0, m0_we = 1'b0;
    logic [AW-1:0] m0_adr = '0;
    logic [DW-1:0] m0_dat = '0;
    logic          m1_cyc = 1'b0, m1_stb = 1'b0, m1_we = 1'b0;
    logic [AW-1:0] m1_adr = '0;
    logic [DW-1:0] m1_dat = '0;
    logic [DW-1:0] m0_dat_o, m1_dat_o, s_dat_o;
    logic          m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
    logic          s_cyc_o, s_stb_o, s_we_o;
    logic [AW-1:0] s_adr_o;
    logic [1:0]    grant_o;

    logic [DW-1:0] slv_mem [0:255];
    logic [DW-1:0] s_dat_r = '0;
    logic          s_ack_r = 1'b0;
    logic          ack_en  = 1'b1;

    mreq_t mq0[$];
    mreq_t mq1[$];
    exp_t  exp_q[$];
    int    ack_cnt [2];
    int    n_checks = 0;
    int    n_fail   = 0;

    always #5 clk = ~clk;

    wb_mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr), .m0_dat_i(m0_dat),
        .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr), .m1_dat_i(m1_dat),
        .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
        .s_dat_i(s_dat_r), .s_ack_i(s_ack_r), .grant_o(grant_o)
    );

    // Slave: registered read data and a one-cycle registered ack per strobe.
    always @(posedge clk) begin
        if (s_cyc_o && s_stb_o && s_we_o)
            slv_mem[s_adr_o[7:0]] <= s_dat_o;
        s_dat_r <= slv_mem[s_adr_o[7:0]];
        s_ack_r <= ack_en && s_cyc_o && s_stb_o && !s_ack_r;
    end

    task automatic drive_masters();
        if (mq0.size() > 0) begin
            m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = mq0[0].we; m0_adr = mq0[0].adr; m0_dat = mq0[0].dat;
        end else begin
            m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0; m0_adr = '0; m0_dat = '0;
        end
        if (mq1.size() > 0) begin
            m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = mq1[0].we; m1_adr = mq1[0].adr; m1_dat = mq1[0].dat;
        end else begin
            m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0; m1_adr = '0; m1_dat = '0;
        end
    endtask

    // Leaves the bench 2 time units into the first IDLE cycle after reset (cycle 0).
    task automatic do_reset();
        mq0.delete(); mq1.delete(); exp_q.delete();
        drive_masters();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
    endtask

    // Runs the master queues until drained, checking every ack against the scoreboard front.
    task automatic serve(input int budget);
        int    cyc;
        bit    gap_chk;
        bit    a0, a1;
        int    n;
        exp_t  e;
        mreq_t r;
        cyc = 0;
        gap_chk = 1'b0;
        drive_masters();
        #1;
        forever begin
            if (gap_chk) begin
                n_checks++;
                if (grant_o !== 2'b00 || s_stb_o !== 1'b0 || m0_dat_o !== '0 || m1_dat_o !== '0) begin
                    n_fail++;
                    $display("FAIL gap_cycle: cyc=%0d grant=%b stb=%b dat0=%h dat1=%h, required grant=00 stb=0 dat=0",
                             cyc, grant_o, s_stb_o, m0_dat_o, m1_dat_o);
                end
            end
            if (mq0.size() == 0 && mq1.size() == 0 && exp_q.size() == 0) break;
            if (cyc >= budget) begin
                n_checks++;
                n_fail++;
                $display("FAIL serve_budget: %0d expected acks outstanding after %0d cycles, required 0", exp_q.size(), cyc);
                break;
            end
            a0 = m0_ack_o;
            a1 = m1_ack_o;
            n_checks++;
            if (m0_err_o !== 1'b0 || m1_err_o !== 1'b0 || (a0 && a1)) begin
                n_fail++;
                $display("FAIL no_err_single_ack: cyc=%0d err0=%b err1=%b ack0=%b ack1=%b, required no err and at most one ack",
                         cyc, m0_err_o, m1_err_o, a0, a1);
            end
            if (a0 || a1) begin
                n = a1 ? 1 : 0;
                if (exp_q.size() == 0 || (n == 0 && mq0.size() == 0) || (n == 1 && mq1.size() == 0)) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_ack: cyc=%0d master=%0d, required no ack", cyc, n);
                end else begin
                    e = exp_q.pop_front();
                    r = (n == 0) ? mq0[0] : mq1[0];
                    n_checks++;
                    if (e.m !== n || e.cyc !== cyc || grant_o !== ((n == 1) ? 2'b10 : 2'b01)) begin
                        n_fail++;
                        $display("FAIL ack_order: ack master=%0d cyc=%0d grant=%b, required master=%0d cyc=%0d",
                                 n, cyc, grant_o, e.m, e.cyc);
                    end
                    n_checks++;
                    if (s_we_o !== r.we || s_adr_o !== r.adr || (r.we && s_dat_o !== r.dat)) begin
                        n_fail++;
                        $display("FAIL slave_pass: we=%b adr=%h dat=%h, required we=%b adr=%h dat=%h",
                                 s_we_o, s_adr_o, s_dat_o, r.we, r.adr, r.dat);
                    end
                    if (e.rd) begin
                        n_checks++;
                        if (((n == 1) ? m1_dat_o : m0_dat_o) !== e.d) begin
                            n_fail++;
                            $display("FAIL read_data: master=%0d got %h, required %h",
                                     n, (n == 1) ? m1_dat_o : m0_dat_o, e.d);
                        end
                    end
                    ack_cnt[n]++;
                end
            end
            gap_chk = a0 || a1;
            @(posedge clk);
            #1;
            if (a0 && mq0.size() > 0) void'(mq0.pop_front());
            if (a1 && mq1.size() > 0) void'(mq1.pop_front());
            drive_masters();
            #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 14'h5;
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 14'h6;
        repeat (2) begin
            @(posedge clk);
            #2;
            n_checks++;
            if ({grant_o, s_cyc_o, s_stb_o, s_we_o, m0_ack_o, m0_err_o, m1_ack_o, m1_err_o} !== 9'd0 ||
                s_adr_o !== '0 || s_dat_o !== '0 || m0_dat_o !== '0 || m1_dat_o !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs: grant=%b cyc=%b stb=%b ack0=%b ack1=%b adr=%h, required all 0",
                         grant_o, s_cyc_o, s_stb_o, m0_ack_o, m1_ack_o, s_adr_o);
            end
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (grant_o !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_idle: grant=%b, required 00", grant_o);
        end
        @(posedge clk);
        #2;
        n_checks++;
        if (grant_o !== 2'b01 || s_adr_o !== 14'h5) begin
            n_fail++;
            $display("FAIL reset_first_winner: grant=%b adr=%h, required grant=01 adr=0005", grant_o, s_adr_o);
        end
    endtask

    task automatic test_write_read();
        do_reset();
        mq0.push_back('{we: 1'b1, adr: 14'h10, dat: 32'hDEADBEEF});
        mq0.push_back('{we: 1'b0, adr: 14'h10, dat: 32'h0});
        exp_q.push_back('{m: 0, rd: 1'b0, d: 32'h0, cyc: 2});
        exp_q.push_back('{m: 0, rd: 1'b1, d: 32'hDEADBEEF, cyc: 5});
        serve(20);
    endtask

    task automatic test_simultaneous();
        do_reset();
        mq0.push_back('{we: 1'b1, adr: 14'h30, dat: 32'h11111111});
        mq1.push_back('{we: 1'b0, adr: 14'h10, dat: 32'h0});
        exp_q.push_back('{m: 0, rd: 1'b0, d: 32'h0, cyc: 2});
        exp_q.push_back('{m: 1, rd: 1'b1, d: 32'hDEADBEEF, cyc: 5});
        serve(20);
    endtask

    task automatic test_back_to_back();
        int j;
        do_reset();
        ack_cnt[0] = 0;
        ack_cnt[1] = 0;
        for (int i = 0; i < 4; i++) begin
            mq0.push_back('{we: (i % 2 == 0), adr: 14'h20 + 14'(i / 2), dat: 32'hA5A50000 + 32'(i / 2)});
            mq1.push_back('{we: (i % 2 == 0), adr: 14'h40 + 14'(i / 2), dat: 32'h5A5A0000 + 32'(i / 2)});
        end
        for (int k = 0; k < 8; k++) begin
            j = k / 2;
            exp_q.push_back('{m: k % 2, rd: (j % 2 == 1),
                              d: ((k % 2 == 0) ? 32'hA5A50000 : 32'h5A5A0000) + 32'(j / 2),
                              cyc: 2 + 3 * k});
        end
        serve(60);
        n_checks++;
        if (ack_cnt[0] !== 4 || ack_cnt[1] !== 4) begin
            n_fail++;
            $display("FAIL b2b_ack_count: m0=%0d m1=%0d, required 4 and 4", ack_cnt[0], ack_cnt[1]);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        ack_en = 1'b0;
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b0; m1_adr = 14'h10;
        #1;
        for (int c = 1; c <= TO + 3; c++) begin
            @(posedge clk);
            #1;
            if (c == TO + 2) begin
                m1_cyc = 1'b0;
                m1_stb = 1'b0;
            end
            #1;
            n_checks++;
            if (grant_o !== ((c <= TO + 1) ? 2'b10 : 2'b00) || m1_err_o !== (c == TO + 1) ||
                m1_ack_o !== 1'b0 || m0_err_o !== 1'b0) begin
                n_fail++;
                $display("FAIL timeout_c%0d: grant=%b err1=%b ack1=%b err0=%b, required grant=%b err1=%b ack1=0 err0=0",
                         c, grant_o, m1_err_o, m1_ack_o, m0_err_o, (c <= TO + 1) ? 2'b10 : 2'b00, (c == TO + 1));
            end
        end
        ack_en = 1'b1;
    endtask

    task automatic test_reset_mid();
        do_reset();
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b0; m0_adr = 14'h10;
        #1;
        @(posedge clk);
        #2;
        n_checks++;
        if (grant_o !== 2'b01 || s_stb_o !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_busy: grant=%b stb=%b, required 01 and 1", grant_o, s_stb_o);
        end
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            n_checks++;
            if ({grant_o, s_cyc_o, s_stb_o, s_we_o, m0_ack_o, m0_err_o, m1_ack_o, m1_err_o} !== 9'd0 ||
                s_adr_o !== '0 || m0_dat_o !== '0) begin
                n_fail++;
                $display("FAIL rstmid_outputs_%0d: grant=%b stb=%b ack0=%b err0=%b, required all 0",
                         k, grant_o, s_stb_o, m0_ack_o, m0_err_o);
            end
            if (k == 0) begin
                @(posedge clk);
                #1;
            end
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (grant_o !== 2'b00 || m0_ack_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_idle: grant=%b ack0=%b, required 00 and 0", grant_o, m0_ack_o);
        end
        @(posedge clk);
        #2;
        n_checks++;
        if (grant_o !== 2'b01 || m0_ack_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_regrant: grant=%b ack0=%b, required 01 and 0", grant_o, m0_ack_o);
        end
        @(posedge clk);
        #2;
        n_checks++;
        if (m0_ack_o !== 1'b1 || m0_dat_o !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL rstmid_ack: ack0=%b dat0=%h, required 1 and deadbeef", m0_ack_o, m0_dat_o);
        end
        @(posedge clk);
        #1;
        m0_cyc = 1'b0; m0_stb = 1'b0;
    endtask

    task automatic test_cyc_drop();
        do_reset();
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b0; m1_adr = 14'h10;
        #1;
        @(posedge clk);
        #2;
        n_checks++;
        if (grant_o !== 2'b10) begin
            n_fail++;
            $display("FAIL drop_busy1: grant=%b, required 10", grant_o);
        end
        m1_cyc = 1'b0; m1_stb = 1'b0;
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b0; m0_adr = 14'h30;
        #1;
        n_checks++;
        if (m1_ack_o !== 1'b0 || m1_err_o !== 1'b0 || s_cyc_o !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_no_ack: ack1=%b err1=%b cyc=%b, required 0 0 0", m1_ack_o, m1_err_o, s_cyc_o);
        end
        @(posedge clk);
        #2;
        n_checks++;
        if (grant_o !== 2'b00 || s_stb_o !== 1'b0 || m1_ack_o !== 1'b0 || m1_err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_gap: grant=%b stb=%b ack1=%b err1=%b, required 00 0 0 0",
                     grant_o, s_stb_o, m1_ack_o, m1_err_o);
        end
        @(posedge clk);
        #2;
        n_checks++;
        if (grant_o !== 2'b01) begin
            n_fail++;
            $display("FAIL drop_next_grant: grant=%b, required 01", grant_o);
        end
        @(posedge clk);
        #2;
        n_checks++;
        if (m0_ack_o !== 1'b1 || m0_dat_o !== 32'h11111111 || m1_ack_o !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_m0_ack: ack0=%b dat0=%h ack1=%b, required 1 11111111 0", m0_ack_o, m0_dat_o, m1_ack_o);
        end
        @(posedge clk);
        #1;
        m0_cyc = 1'b0; m0_stb = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_simultaneous();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        test_cyc_drop();
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/wb_mem_arbiter.md
WB_MEM_ARBITER -- requirements
Module: wb_mem_arbiter

Interface
REQ-001 Parameters: DATA_WIDTH, default 32, data bus width; ADDR_WIDTH, default 14, word-address width; TIMEOUT, default 15, max BUSY cycles without slave ack before abort (1..255).
REQ-002 Reset is rst, synchronous, active-high; clock is clk.
REQ-003 Ports, in order: clk input 1, clock. rst input 1, synchronous active-high reset.
REQ-004 mN_cyc_i, mN_stb_i, mN_we_i (N=0,1) input 1 each; master N cycle, strobe and write enable.
REQ-005 mN_adr_i input ADDR_WIDTH, master N word address; mN_dat_i input DATA_WIDTH, master N write data.
REQ-006 mN_dat_o output DATA_WIDTH, read data to master N; mN_ack_o output 1, ack; mN_err_o output 1, timeout error.
REQ-007 s_cyc_o, s_stb_o, s_we_o output 1 each; slave cycle, strobe, write enable.
REQ-008 s_adr_o output ADDR_WIDTH; s_dat_o output DATA_WIDTH; s_dat_i input DATA_WIDTH; s_ack_i input 1.
REQ-009 grant_o output 2, one-hot owner status: bit N set while master N owns the slave (BUSY_N).

Function
REQ-010 The FSM SHALL have states IDLE, BUSY0, BUSY1 and GAP; reset state is IDLE.
REQ-011 A master SHALL be requesting when mN_cyc_i && mN_stb_i.
REQ-012 Arbitration SHALL occur in IDLE and GAP: one requester goes to BUSY of that master; none goes to IDLE.
REQ-013 Two requesters SHALL be resolved round-robin: grant the master not equal to last_grant; last_grant resets to 1, so master 0 wins first.
REQ-014 last_grant SHALL update on every entry into BUSY_N.
REQ-015 In BUSY_N, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o SHALL combinationally follow master N; elsewhere all slave outputs SHALL be 0.
REQ-016 In BUSY_N, mN_ack_o SHALL equal s_ack_i && mN_stb_i, combinationally.
REQ-017 In BUSY_N, mN_dat_o SHALL equal s_dat_i; at all other times both mN_dat_o SHALL be 0.
REQ-018 Acks, errors and data SHALL never reach the non-granted master.
REQ-019 BUSY_N SHALL go to GAP on the edge after s_ack_i=1 is sampled.
REQ-020 GAP SHALL last exactly one cycle with s_stb_o=0, so the slave's registered ack clears before the next grant; s_ack_i SHALL be ignored outside BUSY.
REQ-021 A BUSY-cycle counter SHALL clear on BUSY entry and increment each BUSY cycle without ack.
REQ-022 If the counter reaches TIMEOUT, mN_err_o SHALL pulse 1 for that cycle, no ack SHALL be issued, and the FSM SHALL go to GAP.
REQ-023 If master N drops mN_cyc_i during BUSY_N before ack, the FSM SHALL go to GAP next edge with no ack or err.
REQ-024 Minimum latency SHALL be: request in IDLE at cycle 0, BUSY at cycle 1, ack and data to master at cycle 2, GAP at cycle 3, next grant at cycle 4.
REQ-025 Slave write repeats during the ack cycle (stb still high) SHALL be tolerated as same-address, same-data rewrites.

Reset
REQ-026 On rst the FSM SHALL enter IDLE, counter SHALL be 0, and last_grant SHALL be 1.
REQ-027 During rst all outputs SHALL be 0: grant_o=2'b00, all acks and errs 0, all slave outputs 0.
REQ-028 rst mid-transaction SHALL abort it with no ack or err; requests still held after rst deasserts SHALL be re-arbitrated from IDLE.

Verification
REQ-029 M0 writes 0xDEADBEEF to adr 0x0010, then reads it: m0_ack_o at cycle 2 of each access; read returns 0xDEADBEEF; grant_o=01 in BUSY.
REQ-030 Both masters request in the same cycle after reset, held until acked: M0 served first, then M1 granted at cycle 4 (after GAP).
REQ-031 Both masters hold continuous back-to-back requests for 8 transactions: grants alternate 0,1,0,1; each master receives 4 acks.
REQ-032 Slave ack tied low, M1 reads: m1_err_o=1 exactly TIMEOUT cycles after entering BUSY1; no ack; GAP, then IDLE.
REQ-033 rst asserted during BUSY0: next cycle all outputs 0 and state IDLE; M0 request still held is re-granted after rst deasserts.
REQ-034 M1 drops cyc during BUSY1 before ack: GAP follows; no m1_ack_o or m1_err_o; M0 request pending is granted next.
